// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, status bit positions, TX FSM encoding and a status packer.
package uart_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Builds the 32-bit STATUS word; unused upper bits read as zero.
  function automatic logic [31:0] pack_status(input logic full,
                                              input logic empty,
                                              input logic busy,
                                              input logic ovf);
    logic [31:0] s;
    s           = '0;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_BUSY]  = busy;
    s[ST_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output. Pointers carry one extra wrap
// bit so full and empty are distinguished without an occupancy counter.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The head entry is presented combinationally so a pop can load it directly.
  assign dout = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  // Pointer update; reset empties the FIFO by aligning both pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue bytes in a
// FIFO, STATUS reports {ovf, busy, empty, full}, and a four-state FSM
// serialises queued bytes back to back onto a registered tx line.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             ovf_reg;
  logic [31:0]      rdata_reg;

  logic             hit_txdata;
  logic             hit_status;
  logic             push_req;
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             baud_done;
  logic             busy;
  logic             unused_wdata;

  assign hit_txdata   = (addr == BASE_ADDR + TXDATA_OFS);
  assign hit_status   = (addr == BASE_ADDR + STATUS_OFS);
  assign push_req     = we && hit_txdata;
  assign baud_done    = (baud_cnt_reg == CNT_LAST);
  assign busy         = (state_reg != IDLE);
  assign unused_wdata = ^wdata[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register plus the FSM's counters, shift register and tx flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
    end
  end

  // Next-state logic; a pop happens whenever a new frame is started.
  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          fifo_pop   = 1'b1;
        end
      end
      START: begin
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        if (baud_done && (bit_idx_reg == 3'd7)) state_next = STOP;
      end
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            state_next = START;
            fifo_pop   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  // Datapath and output logic; tx is driven from the upcoming state so the
  // registered line lines up with the state it belongs to.
  always_comb begin
    baud_cnt_next = baud_cnt_reg + CNT_W'(1);
    if ((state_reg == IDLE) || (state_next != state_reg) || baud_done) begin
      baud_cnt_next = '0;
    end

    bit_idx_next = bit_idx_reg;
    if (state_reg != DATA) begin
      bit_idx_next = '0;
    end else if (baud_done) begin
      bit_idx_next = bit_idx_reg + 3'd1;
    end

    shift_next = shift_reg;
    if (fifo_pop) begin
      shift_next = fifo_dout;
    end else if ((state_reg == DATA) && baud_done) begin
      shift_next = {1'b0, shift_reg[7:1]};
    end

    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // Sticky overflow flag; a same-cycle overflow beats a software clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_reg <= 1'b0;
    end else if (push_req && fifo_full) begin
      ovf_reg <= 1'b1;
    end else if (we && hit_status && wdata[ST_OVF]) begin
      ovf_reg <= 1'b0;
    end
  end

  // Registered read port; STATUS uses pre-edge state, everything else reads 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (hit_status) begin
      rdata_reg <= pack_status(fifo_full, fifo_empty, busy, ovf_reg);
    end else begin
      rdata_reg <= '0;
    end
  end

  assign rdata = rdata_reg;
  assign tx    = tx_reg;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A queue-and-timeline model predicts tx and rdata every cycle; directed
// checks with literal values pin the model, then random traffic follows.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        tx;

  int checks = 0;
  int errors = 0;

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]  m_q[$];
  bit          m_active;
  logic [7:0]  m_cur;
  int          m_start;
  bit          m_ovf;
  int          cyc = 0;
  logic        exp_tx = 1'b1;
  logic [31:0] exp_rdata = '0;
  bit          en_cmp = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit full_pre, empty_pre, busy_pre, set_ovf;
    cyc++;
    if (reset) begin
      m_q.delete();
      m_active  = 0;
      m_ovf     = 0;
      exp_tx    = 1'b1;
      exp_rdata = '0;
    end else begin
      full_pre  = (m_q.size() == DEPTH);
      empty_pre = (m_q.size() == 0);
      busy_pre  = m_active;
      if (addr == BASE + 32'd4)
        exp_rdata = {28'b0, m_ovf, busy_pre, empty_pre, full_pre};
      else
        exp_rdata = '0;
      if (m_active && (cyc == m_start + FRAME)) begin
        if (!empty_pre) begin
          m_cur   = m_q.pop_front();
          m_start = cyc;
        end else begin
          m_active = 0;
        end
      end else if (!m_active && !empty_pre) begin
        m_cur    = m_q.pop_front();
        m_active = 1;
        m_start  = cyc;
      end
      set_ovf = 0;
      if (we && addr == BASE) begin
        if (full_pre) set_ovf = 1;
        else m_q.push_back(wdata[7:0]);
      end
      if (set_ovf) m_ovf = 1;
      else if (we && addr == BASE + 32'd4 && wdata[3]) m_ovf = 0;
      exp_tx = m_active ? frame_bit(m_cur, (cyc - m_start) / CPB) : 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic        want_tx;
    logic [31:0] want_rd;
    if (en_cmp) begin
      want_tx = reset ? 1'b1 : exp_tx;
      want_rd = reset ? 32'h0 : exp_rdata;
      checks++;
      if (tx !== want_tx) begin
        errors++;
        $display("FAIL model_tx at t=%0t: got %b expected %b", $time, tx, want_tx);
      end
      checks++;
      if (rdata !== want_rd) begin
        errors++;
        $display("FAIL model_rdata at t=%0t: got %h expected %h", $time, rdata, want_rd);
      end
    end
  end

  // Start-bit monitor: records the cycle of every 1->0 transition on tx.
  int   falls[$];
  int   ncyc = 0;
  logic prev_tx = 1'b1;
  always @(negedge clk) begin
    if (prev_tx === 1'b1 && tx === 1'b0) falls.push_back(ncyc);
    prev_tx = tx;
    ncyc++;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = w;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
    drive(a, 32'h0, 1'b0);
    @(negedge clk);
    v    = rdata;
    addr = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'h0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return BASE;
      1:       return BASE + 32'd4;
      2:       return BASE + 32'd8;
      3:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    logic [9:0]  pat;
    int          thr;

    reset = 1'b1;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    en_cmp = 1;

    // Reset state
    read_reg(BASE + 32'd4, v);
    chk("reset_status", v, 32'h2);
    chk("reset_tx", {31'b0, tx}, 32'h1);

    // Single frame of 8'hA5: start, LSB-first data, stop
    pat = 10'b11_0100_1010;
    drive(BASE, 32'hA5, 1'b1);
    drive(32'h0, 32'h0, 1'b0);
    chk("a5_tx_before_pop", {31'b0, tx}, 32'h1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk($sformatf("a5_bit%0d_c%0d", i / CPB, i % CPB), {31'b0, tx}, {31'b0, pat[i/CPB]});
    end
    idle(2);
    read_reg(BASE + 32'd4, v);
    chk("a5_status_after", v, 32'h2);

    // Five consecutive stores: contiguous frames, nothing dropped
    falls.delete();
    for (int i = 0; i < 5; i++) drive(BASE, 32'hFF, 1'b1);
    drive(32'h0, 32'h0, 1'b0);
    idle(5 * FRAME);
    chk("burst5_frames", falls.size(), 5);
    for (int i = 0; i + 1 < falls.size(); i++)
      chk($sformatf("burst5_gap%0d", i), falls[i+1] - falls[i], FRAME);
    read_reg(BASE + 32'd4, v);
    chk("burst5_status", v, 32'h2);

    // Six consecutive stores: the sixth overflows
    for (int i = 0; i < 6; i++) drive(BASE, $urandom, 1'b1);
    drive(32'h0, 32'h0, 1'b0);
    read_reg(BASE + 32'd4, v);
    chk("ovf_set", v & 32'h8, 32'h8);
    drive(BASE + 32'd4, 32'h8, 1'b1);
    read_reg(BASE + 32'd4, v);
    chk("ovf_cleared", v & 32'h8, 32'h0);
    idle(6 * FRAME);
    read_reg(BASE + 32'd4, v);
    chk("ovf_drained_status", v, 32'h2);

    // Reset during the data bits
    drive(BASE, 32'h3C, 1'b1);
    drive(32'h0, 32'h0, 1'b0);
    idle(10);
    drive(BASE + 32'd4, 32'h0, 1'b0);
    @(negedge clk);
    chk("mid_status", rdata, 32'h6);
    #1 reset = 1'b1;
    #1;
    chk("reset_async_tx", {31'b0, tx}, 32'h1);
    chk("reset_async_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    addr  = 32'h0;
    read_reg(BASE + 32'd4, v);
    chk("post_reset_status", v, 32'h2);
    idle(FRAME + 5);
    chk("post_reset_tx", {31'b0, tx}, 32'h1);

    // Unmapped and TXDATA reads, unmapped writes
    drive(BASE + 32'd8, 32'h55, 1'b1);
    drive(32'h0, 32'h66, 1'b1);
    drive(32'h0, 32'h0, 1'b0);
    read_reg(BASE + 32'd8, v);
    chk("unmapped_rd8", v, 32'h0);
    read_reg(32'h0, v);
    chk("unmapped_rd0", v, 32'h0);
    read_reg(BASE, v);
    chk("txdata_read", v, 32'h0);
    read_reg(BASE + 32'd4, v);
    chk("unmapped_status", v, 32'h2);
    chk("unmapped_tx", {31'b0, tx}, 32'h1);

    // Random traffic: a dense phase that overflows, then a sparse phase
    for (int ph = 0; ph < 2; ph++) begin
      thr = (ph == 0) ? 3 : 40;
      for (int i = 0; i < 1500; i++) begin
        int r;
        r = int'($urandom_range(0, thr + 5));
        if (r <= 1) drive(BASE, $urandom, 1'b1);
        else if (r == 2) drive(BASE + 32'd4, $urandom, 1'b1);
        else if (r == 3) drive(pick_addr(), $urandom, 1'b1);
        else if (r == 4) drive(BASE + 32'd4, $urandom, 1'b0);
        else if (r == 5) drive(pick_addr(), 32'h0, 1'b0);
        else drive(32'h0, 32'h0, 1'b0);
      end
    end
    idle((DEPTH + 2) * FRAME);
    drive(BASE + 32'd4, 32'h8, 1'b1);
    read_reg(BASE + 32'd4, v);
    chk("final_status", v, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
